nanov_store_io: RTL and testbench

- Memory-mapped output peripheral directly downstream of the nanoV CPU core.
- Consumes the serialised store stream: the address word (qualified by `store_addr_out`), then the bit-reversed data word (qualified by `store_data_out`).
- Decodes stores to the peripheral region: drives a GPIO output register and feeds a small TX FIFO into an 8N1 UART transmitter.

---
 rtl/nanov_store_io.sv | 205 ++++++++++++++++++++
 tb/tb_nanov_store_io.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nanov_store_io.sv
// nanov_store_io: decodes the nanoV serial store stream into a GPIO output register and a FIFO-fed 8N1 UART TX.
// Optional: define NANOV_GPIO_SET_CLR_EN to add GPIO_SET (select 2) and GPIO_CLR (select 3).
module nanov_store_io #(
   parameter int GPIO_WIDTH   = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int CLKS_PER_BIT = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [31:0]           cpu_data,
   input  logic                  store_addr_out,
   input  logic                  store_data_out,
   output logic [GPIO_WIDTH-1:0] gpio_out,
   output logic                  uart_tx,
   output logic                  uart_busy,
   output logic                  uart_overflow
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic [31:0]           addr_q;
   logic                  addr_pending_q;
   logic [31:0]           wdata;
   logic                  data_take, hit;
   logic [1:0]            sel;
   logic                  wr_gpio, wr_uart;
   logic [GPIO_WIDTH-1:0] gpio_q;

   logic [7:0]            fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic                  fifo_push, fifo_pop, fifo_drop, fifo_full, fifo_nonempty;
   logic                  overflow_q;

   state_t                state_q, state_d;
   logic [BAUD_W-1:0]     baud_q, baud_d;
   logic [2:0]            bit_q, bit_d;
   logic [7:0]            shift_q, shift_d;
   logic                  tx_q, tx_d, busy_q, bit_done;

   // The core serialises data MSB-first onto the bus, so the word arrives bit-reversed.
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_rev
         assign wdata[gi] = cpu_data[31-gi];
      end
   endgenerate

   assign data_take = store_data_out && addr_pending_q;
   assign hit       = (addr_q[31:24] == 8'h10);
   assign sel       = addr_q[3:2];
   assign wr_gpio   = data_take && hit && (sel == 2'd0);
   assign wr_uart   = data_take && hit && (sel == 2'd1);

`ifdef NANOV_GPIO_SET_CLR_EN
   logic wr_set, wr_clr;
   assign wr_set = data_take && hit && (sel == 2'd2);
   assign wr_clr = data_take && hit && (sel == 2'd3);
`endif

   // A data strobe consumes the old address before a same-cycle address strobe replaces it.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         addr_q         <= '0;
         addr_pending_q <= 1'b0;
      end else if (store_addr_out) begin
         addr_q         <= cpu_data;
         addr_pending_q <= 1'b1;
      end else if (store_data_out) begin
         addr_pending_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn)
         gpio_q <= '0;
      else if (wr_gpio)
         gpio_q <= wdata[GPIO_WIDTH-1:0];
`ifdef NANOV_GPIO_SET_CLR_EN
      else if (wr_set)
         gpio_q <= gpio_q | wdata[GPIO_WIDTH-1:0];
      else if (wr_clr)
         gpio_q <= gpio_q & ~wdata[GPIO_WIDTH-1:0];
`endif
   end

   assign fifo_full     = (count_q == CNT_W'(FIFO_DEPTH));
   assign fifo_nonempty = (count_q != '0);
   assign fifo_push     = wr_uart && (!fifo_full || fifo_pop);
   assign fifo_drop     = wr_uart && fifo_full && !fifo_pop;

   always_ff @(posedge clk) begin
      if (fifo_push)
         fifo_mem[wr_ptr_q] <= wdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (fifo_push)
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (fifo_pop)
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (fifo_push && !fifo_pop)
            count_q <= count_q + CNT_W'(1);
         else if (!fifo_push && fifo_pop)
            count_q <= count_q - CNT_W'(1);
         if (fifo_drop)
            overflow_q <= 1'b1;
      end
   end

   assign bit_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      tx_d     = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (fifo_nonempty) begin
               fifo_pop = 1'b1;
               state_d  = S_START;
               baud_d   = '0;
            end
         end
         S_START: begin
            if (bit_done) begin
               state_d = S_DATA;
               baud_d  = '0;
               bit_d   = 3'd0;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (bit_done) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7)
                  state_d = S_STOP;
               else
                  bit_d = bit_q + 3'd1;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            // Chain straight into the next start bit so queued bytes go out back-to-back.
            if (bit_done) begin
               baud_d = '0;
               if (fifo_nonempty) begin
                  fifo_pop = 1'b1;
                  state_d  = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
      endcase
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= fifo_pop ? fifo_mem[rd_ptr_q] : shift_d;
         tx_q    <= tx_d;
         busy_q  <= fifo_nonempty || (state_q != S_IDLE);
      end
   end

   assign gpio_out      = gpio_q;
   assign uart_tx       = tx_q;
   assign uart_busy     = busy_q;
   assign uart_overflow = overflow_q;

   logic unused_bits;
   assign unused_bits = &{1'b0, addr_q[23:4], addr_q[1:0], wdata};
endmodule

// File: tb/tb_nanov_store_io.sv
// Randomised scoreboard bench for nanov_store_io: a timing-level model predicts GPIO, UART frames, busy and overflow.
module tb_nanov_store_io;
   localparam int GW    = 8;
   localparam int DEPTH = 4;
   localparam int CPB   = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [31:0]   cpu_data = '0;
   logic          store_addr_out = 1'b0;
   logic          store_data_out = 1'b0;
   logic [GW-1:0] gpio_out;
   logic          uart_tx, uart_busy, uart_overflow;

   nanov_store_io #(.GPIO_WIDTH(GW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rstn(rstn), .cpu_data(cpu_data),
      .store_addr_out(store_addr_out), .store_data_out(store_data_out),
      .gpio_out(gpio_out), .uart_tx(uart_tx), .uart_busy(uart_busy), .uart_overflow(uart_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         push;
      int         pop;
      logic [7:0] data;
   } frame_t;

   int            checks = 0;
   int            errors = 0;
   int            edge_cnt = 0;
   logic          rst_edge = 1'b0;
   bit            mon_en = 1'b0;
   frame_t        items[$];
   frame_t        exp_q[$];
   int            tx_free = 0;
   int            ovf_edge = -1;
   int            gpio_edge = 0;
   logic [GW-1:0] gpio_cur = '0;
   logic [GW-1:0] gpio_prev = '0;
   logic          pend = 1'b0;
   logic [31:0]   paddr = '0;
   bit            rx_active = 1'b0;
   int            rx_start = 0;
   logic [7:0]    rx_byte = '0;
   frame_t        rx_cur;

   always @(posedge clk) begin
      edge_cnt <= edge_cnt + 1;
      rst_edge <= !rstn;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, edge_cnt);
      end
   endtask

   function automatic logic [31:0] bitrev(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   function automatic int occupancy(input int e);
      int n = 0;
      foreach (items[i]) if (items[i].pop > e) n++;
      return n;
   endfunction

   task automatic set_gpio(input logic [GW-1:0] v, input int e);
      gpio_prev = gpio_cur;
      gpio_cur  = v;
      gpio_edge = e;
   endtask

   // Reference: a UART byte accepted at edge e is popped when the line is free, then owns 10 bit times.
   task automatic model_write(input logic [31:0] addr, input logic [31:0] wd, input int e);
      frame_t f;
      int     p;
      if (addr[31:24] != 8'h10) return;
      case (addr[3:2])
         2'd0: set_gpio(wd[GW-1:0], e);
         2'd1: begin
            if (occupancy(e) >= DEPTH) begin
               if (ovf_edge < 0) ovf_edge = e;
            end else begin
               p = (e + 1 > tx_free) ? e + 1 : tx_free;
               tx_free = p + 10*CPB;
               f.push = e; f.pop = p; f.data = wd[7:0];
               items.push_back(f);
               exp_q.push_back(f);
            end
         end
`ifdef NANOV_GPIO_SET_CLR_EN
         2'd2: set_gpio(gpio_cur | wd[GW-1:0], e);
         default: set_gpio(gpio_cur & ~wd[GW-1:0], e);
`else
         default: ;
`endif
      endcase
   endtask

   task automatic cyc(input logic sa, input logic sd, input logic [31:0] bus);
      int e;
      @(negedge clk); #1;
      store_addr_out = sa;
      store_data_out = sd;
      cpu_data = bus;
      e = edge_cnt + 1;
      if (sd && pend) begin
         model_write(paddr, bitrev(bus), e);
         pend = 1'b0;
      end
      if (sa) begin
         paddr = bus;
         pend = 1'b1;
      end
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      cyc(1'b1, 1'b0, addr);
      cyc(1'b0, 1'b1, bitrev(data));
      cyc(1'b0, 1'b0, $urandom);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk); #1;
      rstn = 1'b0;
      store_addr_out = 1'b0;
      store_data_out = 1'b0;
      exp_q.delete();
      items.delete();
      tx_free = 0;
      ovf_edge = -1;
      pend = 1'b0;
      set_gpio('0, edge_cnt + 1);
      repeat (n) begin @(negedge clk); #1; end
      rstn = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 3000 && (exp_q.size() != 0 || rx_active); i++) @(negedge clk);
      check("drain_exp_q", exp_q.size(), 0);
      repeat (CPB*2) cyc(1'b0, 1'b0, $urandom);
   endtask

   // Monitor: compares registered outputs every cycle and decodes frames off uart_tx.
   always @(negedge clk) begin : monitor
      int   k;
      int   off;
      logic exp_busy;
      if (mon_en) begin
         k = edge_cnt;
         exp_busy = 1'b0;
         foreach (items[i])
            if (items[i].push <= k - 1 && k - 1 < items[i].pop + 10*CPB) exp_busy = 1'b1;
         check("uart_busy", uart_busy, exp_busy);
         check("uart_overflow", uart_overflow, (ovf_edge >= 0 && ovf_edge <= k));
         check("gpio_out", gpio_out, (k >= gpio_edge) ? gpio_cur : gpio_prev);
         if (rst_edge) begin
            rx_active = 1'b0;
         end else if (!rx_active) begin
            if (exp_q.size() == 0)
               check("uart_tx_idle", uart_tx, 1);
            else if (uart_tx == 1'b0) begin
               rx_cur = exp_q.pop_front();
               check("start_edge", k, rx_cur.pop);
               rx_start = k;
               rx_active = 1'b1;
               rx_byte = '0;
            end
         end else begin
            off = k - rx_start;
            if (off == CPB/2)
               check("start_bit", uart_tx, 0);
            else if (off % CPB == CPB/2 && off/CPB >= 1 && off/CPB <= 8)
               rx_byte[off/CPB-1] = uart_tx;
            else if (off == 9*CPB + CPB/2) begin
               check("stop_bit", uart_tx, 1);
               check("rx_byte", rx_byte, rx_cur.data);
               $display("frame %h start edge %0d", rx_byte, rx_start);
               rx_active = 1'b0;
            end
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
      $fatal(1);
   end

   initial begin
      int busy_cnt;
      int p;
      int kind;
      repeat (4) @(negedge clk);
      #1;
      rstn = 1'b1;
      mon_en = 1'b1;
      check("rst_gpio", gpio_out, 0);
      check("rst_tx", uart_tx, 1);
      check("rst_busy", uart_busy, 0);
      check("rst_ovf", uart_overflow, 0);

      // GPIO write with a long gap between address and data
      cyc(1'b1, 1'b0, 32'h1000_0000);
      repeat (31) cyc(1'b0, 1'b0, $urandom);
      cyc(1'b0, 1'b1, 32'hA500_0000);
      cyc(1'b0, 1'b0, $urandom);
      check("gpio_a5", gpio_out, 8'hA5);

      // single UART byte: start bit two cycles after the strobe, busy 10 bit times + 1
      cyc(1'b1, 1'b0, 32'h1000_0004);
      cyc(1'b0, 1'b1, bitrev(32'h55));
      busy_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         cyc(1'b0, 1'b0, $urandom);
         if (uart_busy) busy_cnt++;
      end
      check("busy_cycles", busy_cnt, 10*CPB + 1);
      drain();

      // ignored stores
      store(32'h0000_1000, 32'hFFFF_FFFF);
      cyc(1'b0, 1'b1, 32'hFFFF_FFFF);
      cyc(1'b0, 1'b0, $urandom);
      check("gpio_after_ignored", gpio_out, 8'hA5);
      check("busy_after_ignored", uart_busy, 0);

      // set/clear registers
      store(32'h1000_0000, 32'h0F);
      store(32'h1000_0008, 32'hF0);
      store(32'h1000_000C, 32'h3C);
`ifdef NANOV_GPIO_SET_CLR_EN
      check("gpio_set_clr", gpio_out, 8'hC3);
`else
      check("gpio_set_clr", gpio_out, 8'h0F);
`endif

      // both strobes together: data goes to the old address, new address stays pending
      cyc(1'b1, 1'b0, 32'h1000_0000);
      cyc(1'b1, 1'b1, 32'h1000_0004);
      cyc(1'b0, 1'b1, bitrev(32'h77));
      cyc(1'b0, 1'b0, $urandom);
      check("gpio_both_strobes", gpio_out, 8'h08);
      drain();

      // six bytes into a four-deep FIFO while the first frame is in flight
      for (int b = 1; b <= 6; b++) store(32'h1000_0004, b);
      check("ovf_after_burst", uart_overflow, 1);
      drain();
      check("ovf_sticky", uart_overflow, 1);

      // randomised traffic
      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 7);
         case (kind)
            0, 1: store({8'h10, 20'($urandom), 2'b00, 2'($urandom)}, $urandom);
            2, 3: store({8'h10, 20'($urandom), 2'b01, 2'($urandom)}, $urandom);
            4:    store({8'h10, 20'($urandom), 1'b1, 1'($urandom), 2'($urandom)}, $urandom);
            5:    store({8'($urandom_range(0, 31)), 24'($urandom)}, $urandom);
            6:    cyc(1'b0, 1'b1, $urandom);
            default: begin
               cyc(1'b1, 1'b0, $urandom);
               store({8'h10, 20'($urandom), 2'b01, 2'($urandom)}, $urandom);
            end
         endcase
         repeat ($urandom_range(0, 12)) cyc(1'b0, 1'b0, $urandom);
      end
      drain();

      // reset in the middle of data bit 3
      store(32'h1000_0004, 32'hC3);
      p = items[items.size()-1].pop;
      for (int i = 0; i < 400 && edge_cnt < p + 4*CPB; i++) @(negedge clk);
      do_reset(1);
      check("mid_rst_tx", uart_tx, 1);
      check("mid_rst_busy", uart_busy, 0);
      check("mid_rst_ovf", uart_overflow, 0);
      check("mid_rst_gpio", gpio_out, 0);
      store(32'h1000_0004, 32'h5A);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
